// File: rtl/snake_pkg.sv
// Shared menu geometry and selection encoding, common to the menu draw stage
// and the menu input controller.
package snake_pkg;

  localparam int unsigned COORD_W = 12;

  // Button rectangles: one column, three rows, with a gap between rows.
  localparam logic [COORD_W-1:0] BUTTONS_X = 12'd270;
  localparam logic [COORD_W-1:0] BUTTONS_W = 12'd100;
  localparam logic [COORD_W-1:0] BUTTONS_H = 12'd40;
  localparam logic [COORD_W-1:0] BUTTON1_Y = 12'd150;
  localparam logic [COORD_W-1:0] BUTTON2_Y = 12'd210;
  localparam logic [COORD_W-1:0] BUTTON3_Y = 12'd270;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_1P   = 2'd1,
    SEL_2P   = 2'd2,
    SEL_SET  = 2'd3
  } menu_sel_t;

  // Right and bottom edges are exclusive; on overlap the lower index wins.
  function automatic menu_sel_t hit_test(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
    logic in_col;
    menu_sel_t hit;
    in_col = (x >= BUTTONS_X) && (x < BUTTONS_X + BUTTONS_W);
    hit    = SEL_NONE;
    if (in_col && (y >= BUTTON3_Y) && (y < BUTTON3_Y + BUTTONS_H)) hit = SEL_SET;
    if (in_col && (y >= BUTTON2_Y) && (y < BUTTON2_Y + BUTTONS_H)) hit = SEL_2P;
    if (in_col && (y >= BUTTON1_Y) && (y < BUTTON1_Y + BUTTONS_H)) hit = SEL_1P;
    return hit;
  endfunction

endpackage

// File: rtl/menu_ctl_if.sv
// Mouse-in / selection-out bundle between the pointer front end, the menu
// controller and its consumers (draw stage, game-mode FSM).
interface menu_ctl_if;
  import snake_pkg::*;

  logic                en;
  logic [COORD_W-1:0]  mouse_x;
  logic [COORD_W-1:0]  mouse_y;
  logic                mouse_left;
  logic [1:0]          hover_o;
  logic                sel_valid_o;
  logic [1:0]          sel_id_o;
  logic                busy_o;

  modport master (
    output en, mouse_x, mouse_y, mouse_left,
    input  hover_o, sel_valid_o, sel_id_o, busy_o
  );

  modport slave (
    input  en, mouse_x, mouse_y, mouse_left,
    output hover_o, sel_valid_o, sel_id_o, busy_o
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for any mechanical button;
// emits the accepted level and one-cycle press/release events.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned CNT_W        = 18      // 2**CNT_W must exceed DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o,
  output logic press_ev_o,
  output logic rel_ev_o
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        lvl_d   = sync2_q;
        press_d = sync2_q;
        rel_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Events are registered alongside the level, so they coincide with its edge.
  assign btn_o      = lvl_q;
  assign press_ev_o = press_q;
  assign rel_ev_o   = rel_q;

endmodule

// File: rtl/menu_ctl.sv
// Main-menu pointer controller: hit-tests the cursor against the three menu
// buttons and turns a press+release over the same button into a selection.
module menu_ctl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic         clk,
  input  logic         rst,
  menu_ctl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FIRE   = 2'd2,
    ST_CANCEL = 2'd3
  } state_t;

  logic btn_lvl;
  logic press_ev;
  logic rel_ev;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_deb (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (bus.mouse_left),
    .btn_o      (btn_lvl),
    .press_ev_o (press_ev),
    .rel_ev_o   (rel_ev)
  );

  state_t    state_q, state_d;
  menu_sel_t hit_q, hit_d;
  menu_sel_t armed_q, armed_d;
  logic      sel_valid_q, sel_valid_d;
  menu_sel_t sel_id_q, sel_id_d;
  logic      busy_q, busy_d;

  always_comb begin
    hit_d       = hit_test(bus.mouse_x, bus.mouse_y);
    state_d     = state_q;
    armed_d     = armed_q;
    sel_valid_d = 1'b0;
    sel_id_d    = sel_id_q;

    if (!bus.en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_ev) begin
            if (hit_q != SEL_NONE) begin
              state_d = ST_ARMED;
              armed_d = hit_q;
            end else begin
              state_d = ST_CANCEL;
            end
          end
        end
        ST_ARMED: begin
          // Leaving the armed button cancels, even if released the same cycle.
          if (hit_q != armed_q) begin
            state_d = ST_CANCEL;
          end else if (rel_ev) begin
            state_d     = ST_FIRE;
            sel_valid_d = 1'b1;
            sel_id_d    = armed_q;
          end
        end
        ST_FIRE: begin
          state_d = ST_IDLE;
        end
        ST_CANCEL: begin
          if (rel_ev) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CANCEL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hit_q       <= SEL_NONE;
      armed_q     <= SEL_NONE;
      sel_valid_q <= 1'b0;
      sel_id_q    <= SEL_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      armed_q     <= armed_d;
      sel_valid_q <= sel_valid_d;
      sel_id_q    <= sel_id_d;
      busy_q      <= busy_d;
    end
  end

  // sel_valid_q and busy_q are loaded from the next state, so both line up
  // with state_q (sel_valid_o is high exactly while in FIRE).
  assign bus.hover_o     = hit_q;
  assign bus.sel_valid_o = sel_valid_q;
  assign bus.sel_id_o    = sel_id_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_menu_ctl.sv
// Directed bench for menu_ctl: stimulus pushes expected selections into a
// queue, a negedge monitor pops and compares each sel_valid_o pulse.
module tb_menu_ctl;
  import snake_pkg::*;

  localparam logic [11:0] X1  = BUTTONS_X + 12'd5;
  localparam logic [11:0] Y1  = BUTTON1_Y + 12'd5;
  localparam logic [11:0] Y2  = BUTTON2_Y + 12'd5;
  localparam logic [11:0] Y3  = BUTTON3_Y + 12'd5;
  localparam logic [11:0] XE  = BUTTONS_X + BUTTONS_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  menu_ctl_if bus ();

  menu_ctl #(
    .DEBOUNCE_CYC (4),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sel_cnt = 0;
  int press_cnt = 0;
  logic prev_rel = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input logic [11:0] x, input logic [11:0] y);
    bus.mouse_x = x;
    bus.mouse_y = y;
  endtask

  // Monitor: every sel_valid_o cycle consumes one expected id, and must follow
  // a release event in the previous cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.sel_valid_o) begin
        sel_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sel_unexpected: got sel_id %0d, expected no selection", bus.sel_id_o);
        end else begin
          check("sel_id", int'(bus.sel_id_o), exp_q.pop_front());
          check("sel_latency_rel_prev", int'(prev_rel), 1);
        end
      end
      if (dut.u_deb.press_ev_o) press_cnt++;
      prev_rel = dut.u_deb.rel_ev_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first_press;
    int n_press;
    int sel_before;
    int press_before;

    // 1. Reset with the button held, cursor off all buttons.
    rst = 1'b0;
    bus.en = 1'b1;
    bus.mouse_left = 1'b1;
    set_xy(12'd0, 12'd0);
    tick(3);
    check("rst_hover", int'(bus.hover_o), 0);
    check("rst_sel_valid", int'(bus.sel_valid_o), 0);
    check("rst_sel_id", int'(bus.sel_id_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    rst = 1'b1;
    first_press = 0;
    n_press = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (dut.u_deb.press_ev_o) begin
        n_press++;
        if (first_press == 0) first_press = i;
      end
    end
    check("t1_press_count", n_press, 1);
    check("t1_press_cycle", first_press, 6);
    check("t1_busy_cancel", int'(bus.busy_o), 1);
    bus.mouse_left = 1'b0;
    tick(10);
    check("t1_busy_after_rel", int'(bus.busy_o), 0);

    // 2. Click on button 2.
    sel_before = sel_cnt;
    set_xy(X1, Y2);
    tick(2);
    check("t2_hover", int'(bus.hover_o), 2);
    exp_q.push_back(2);
    bus.mouse_left = 1'b1;
    tick(20);
    check("t2_busy_pressed", int'(bus.busy_o), 1);
    bus.mouse_left = 1'b0;
    tick(12);
    check("t2_busy_after", int'(bus.busy_o), 0);
    check("t2_sel_pulses", sel_cnt - sel_before, 1);
    check("t2_sel_id_held", int'(bus.sel_id_o), 2);

    // 3. Drag-off cancel: press on 1, release over 3.
    sel_before = sel_cnt;
    set_xy(X1, Y1);
    tick(2);
    bus.mouse_left = 1'b1;
    tick(10);
    check("t3_busy_armed", int'(bus.busy_o), 1);
    set_xy(X1, Y3);
    tick(3);
    check("t3_busy_cancel", int'(bus.busy_o), 1);
    bus.mouse_left = 1'b0;
    tick(10);
    check("t3_busy_after", int'(bus.busy_o), 0);
    check("t3_hover", int'(bus.hover_o), 3);
    check("t3_sel_pulses", sel_cnt - sel_before, 0);

    // 4. Rectangle edges.
    sel_before = sel_cnt;
    set_xy(XE, Y1);
    tick(2);
    check("t4_right_excl", int'(bus.hover_o), 0);
    set_xy(XE - 12'd1, Y1);
    tick(2);
    check("t4_right_incl", int'(bus.hover_o), 1);
    set_xy(BUTTONS_X - 12'd1, Y1);
    tick(2);
    check("t4_left_outside", int'(bus.hover_o), 0);
    set_xy(X1, BUTTON1_Y + BUTTONS_H - 12'd1);
    tick(2);
    check("t4_bottom_incl", int'(bus.hover_o), 1);
    set_xy(X1, BUTTON1_Y + BUTTONS_H);
    tick(2);
    check("t4_bottom_excl", int'(bus.hover_o), 0);
    set_xy(XE, Y1);
    tick(2);
    bus.mouse_left = 1'b1;
    tick(10);
    check("t4_edge_press_cancel", int'(bus.busy_o), 1);
    bus.mouse_left = 1'b0;
    tick(10);
    check("t4_busy_after", int'(bus.busy_o), 0);
    check("t4_sel_pulses", sel_cnt - sel_before, 0);

    // 5. Glitches of 3 cycles on button 1.
    sel_before = sel_cnt;
    press_before = press_cnt;
    set_xy(X1, Y1);
    tick(2);
    for (int g = 0; g < 3; g++) begin
      bus.mouse_left = 1'b1;
      tick(3);
      bus.mouse_left = 1'b0;
      tick(6);
      check("t5_busy_low", int'(bus.busy_o), 0);
    end
    check("t5_no_press", press_cnt - press_before, 0);
    check("t5_sel_pulses", sel_cnt - sel_before, 0);

    // 6. en drop during a press on button 3.
    sel_before = sel_cnt;
    set_xy(X1, Y3);
    tick(2);
    bus.mouse_left = 1'b1;
    tick(10);
    check("t6_busy_armed", int'(bus.busy_o), 1);
    bus.en = 1'b0;
    tick(1);
    check("t6_idle_next_cycle", int'(bus.busy_o), 0);
    set_xy(X1, Y1);
    tick(2);
    check("t6_hover_while_disabled", int'(bus.hover_o), 1);
    set_xy(X1, Y3);
    bus.mouse_left = 1'b0;
    tick(12);
    check("t6_sel_pulses", sel_cnt - sel_before, 0);
    check("t6_sel_id_kept", int'(bus.sel_id_o), 2);
    check("t6_busy_after", int'(bus.busy_o), 0);

    // Re-enable and make a clean selection of settings.
    sel_before = sel_cnt;
    bus.en = 1'b1;
    tick(2);
    exp_q.push_back(3);
    bus.mouse_left = 1'b1;
    tick(10);
    bus.mouse_left = 1'b0;
    tick(12);
    check("t6_reenable_sel_pulses", sel_cnt - sel_before, 1);
    check("t6_reenable_sel_id", int'(bus.sel_id_o), 3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
